ls_queue_param: RTL

- In-order load/store queue between the dispatcher and the address unit / load buffer, parametrised in depth, CDB channel count and data width.
- Holds memory ops in program order and wakes operands from N CDB channels.
- Issues the head entry when its operands are ready. For stores, also sends the store data to the ROB.
- Improvements: count-based full/empty (all DEPTH slots usable), CDB capture on the dispatch cycle, configurable back-pressure slack, sticky overflow flag.

---
 rtl/ls_queue_param_pkg.sv | 27 ++
 rtl/ls_queue_param_if.sv | 53 +++++
 rtl/lsq_wakeup.sv | 30 +++
 rtl/ls_queue_param.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ls_queue_param_pkg.sv
// rtl/ls_queue_param_pkg.sv - op codes, constants and op-class helpers for the load/store queue
package ls_queue_param_pkg;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  // Tag 0 means the operand has no pending producer and its value is ready
  localparam int unsigned NULL = 0;

  localparam int unsigned LB  = 1;
  localparam int unsigned LH  = 2;
  localparam int unsigned LW  = 3;
  localparam int unsigned LBU = 4;
  localparam int unsigned LHU = 5;
  localparam int unsigned SB  = 6;
  localparam int unsigned SH  = 7;
  localparam int unsigned SW  = 8;

  function automatic logic is_load(input int unsigned t);
    return (t >= LB) && (t <= LHU);
  endfunction

  function automatic logic is_store(input int unsigned t);
    return (t >= SB) && (t <= SW);
  endfunction

endpackage

// File: rtl/ls_queue_param_if.sv
// rtl/ls_queue_param_if.sv - dispatch, CDB, issue and store-data bundle of the load/store queue
interface ls_queue_param_if #(
  parameter int DEPTH  = 16,
  parameter int CDB_CH = 2,
  parameter int XLEN   = 32,
  parameter int TAG_W  = 4,
  parameter int TYPE_W = 6
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                     rdy_in;
  logic                     flush_in;
  logic                     dispatch_en_in;
  logic [TYPE_W-1:0]        dispatch_type_in;
  logic [XLEN-1:0]          dispatch_vj_in;
  logic [XLEN-1:0]          dispatch_vk_in;
  logic [TAG_W-1:0]         dispatch_qj_in;
  logic [TAG_W-1:0]         dispatch_qk_in;
  logic [XLEN-1:0]          dispatch_imm_in;
  logic [TAG_W-1:0]         dispatch_dest_in;
  logic [CDB_CH-1:0]        cdb_en_in;
  logic [CDB_CH*TAG_W-1:0]  cdb_tag_in;
  logic [CDB_CH*XLEN-1:0]   cdb_value_in;
  logic                     lbuffer_rdy_in;
  logic                     instqueue_rdy_out;
  logic [CW-1:0]            count_out;
  logic                     overflow_err_out;
  logic                     rob_en_out;
  logic [TAG_W-1:0]         rob_dest_out;
  logic [XLEN-1:0]          rob_value_out;
  logic                     addr_en_out;
  logic [XLEN-1:0]          addr_imm_out;
  logic [XLEN-1:0]          addr_vj_out;
  logic [TAG_W-1:0]         addr_dest_out;
  logic [TYPE_W-1:0]        addr_type_out;

  modport master (
    output rdy_in, flush_in, dispatch_en_in, dispatch_type_in, dispatch_vj_in, dispatch_vk_in,
           dispatch_qj_in, dispatch_qk_in, dispatch_imm_in, dispatch_dest_in,
           cdb_en_in, cdb_tag_in, cdb_value_in, lbuffer_rdy_in,
    input  instqueue_rdy_out, count_out, overflow_err_out, rob_en_out, rob_dest_out, rob_value_out,
           addr_en_out, addr_imm_out, addr_vj_out, addr_dest_out, addr_type_out
  );

  modport slave (
    input  rdy_in, flush_in, dispatch_en_in, dispatch_type_in, dispatch_vj_in, dispatch_vk_in,
           dispatch_qj_in, dispatch_qk_in, dispatch_imm_in, dispatch_dest_in,
           cdb_en_in, cdb_tag_in, cdb_value_in, lbuffer_rdy_in,
    output instqueue_rdy_out, count_out, overflow_err_out, rob_en_out, rob_dest_out, rob_value_out,
           addr_en_out, addr_imm_out, addr_vj_out, addr_dest_out, addr_type_out
  );

endinterface

// File: rtl/lsq_wakeup.sv
// rtl/lsq_wakeup.sv - captures a CDB value for one (tag, value) operand, lowest channel wins
module lsq_wakeup
  import ls_queue_param_pkg::*;
#(
  parameter int CDB_CH = 2,
  parameter int XLEN   = 32,
  parameter int TAG_W  = 4
) (
  input  logic [TAG_W-1:0]        q_in,
  input  logic [XLEN-1:0]         v_in,
  input  logic [CDB_CH-1:0]       cdb_en_in,
  input  logic [CDB_CH*TAG_W-1:0] cdb_tag_in,
  input  logic [CDB_CH*XLEN-1:0]  cdb_value_in,
  output logic [TAG_W-1:0]        q_out,
  output logic [XLEN-1:0]         v_out
);

  // Scan high to low so the lowest matching channel is the last writer and wins
  always_comb begin
    q_out = q_in;
    v_out = v_in;
    for (int c = CDB_CH - 1; c >= 0; c--) begin
      if ((q_in != TAG_W'(NULL)) && cdb_en_in[c] && (cdb_tag_in[c*TAG_W +: TAG_W] == q_in)) begin
        q_out = TAG_W'(NULL);
        v_out = cdb_value_in[c*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/ls_queue_param.sv
// rtl/ls_queue_param.sv - in-order load/store queue with CDB wakeup and head-only issue
module ls_queue_param
  import ls_queue_param_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int CDB_CH = 2,
  parameter int XLEN   = 32,
  parameter int TAG_W  = 4,
  parameter int TYPE_W = 6,
  parameter int SLACK  = 2
) (
  input logic             clk_in,
  input logic             rst_in,
  ls_queue_param_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0]    RDY_MAX  = CW'(DEPTH - SLACK - 1);
  localparam logic [TAG_W-1:0] TAG_NONE = TAG_W'(NULL);

  logic              r_valid [DEPTH];
  logic [TYPE_W-1:0] r_type  [DEPTH];
  logic [XLEN-1:0]   r_vj    [DEPTH];
  logic [XLEN-1:0]   r_vk    [DEPTH];
  logic [XLEN-1:0]   r_imm   [DEPTH];
  logic [TAG_W-1:0]  r_qj    [DEPTH];
  logic [TAG_W-1:0]  r_qk    [DEPTH];
  logic [TAG_W-1:0]  r_dest  [DEPTH];
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [CW-1:0]     r_count;
  logic              r_overflow;
  logic              r_rob_en;
  logic [TAG_W-1:0]  r_rob_dest;
  logic [XLEN-1:0]   r_rob_value;
  logic              r_addr_en;
  logic [XLEN-1:0]   r_addr_imm;
  logic [XLEN-1:0]   r_addr_vj;
  logic [TAG_W-1:0]  r_addr_dest;
  logic [TYPE_W-1:0] r_addr_type;

  logic [TAG_W-1:0]  w_qj [DEPTH];
  logic [TAG_W-1:0]  w_qk [DEPTH];
  logic [XLEN-1:0]   w_vj [DEPTH];
  logic [XLEN-1:0]   w_vk [DEPTH];
  logic [TAG_W-1:0]  w_dqj;
  logic [TAG_W-1:0]  w_dqk;
  logic [XLEN-1:0]   w_dvj;
  logic [XLEN-1:0]   w_dvk;
  logic              w_head_load;
  logic              w_head_store;
  logic              w_issue;
  logic              w_accept;
  logic [XLEN-1:0]   w_store_data;

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    lsq_wakeup #(.CDB_CH(CDB_CH), .XLEN(XLEN), .TAG_W(TAG_W)) u_wk_j (
      .q_in(r_qj[g]), .v_in(r_vj[g]), .cdb_en_in(bus.cdb_en_in), .cdb_tag_in(bus.cdb_tag_in),
      .cdb_value_in(bus.cdb_value_in), .q_out(w_qj[g]), .v_out(w_vj[g]));
    lsq_wakeup #(.CDB_CH(CDB_CH), .XLEN(XLEN), .TAG_W(TAG_W)) u_wk_k (
      .q_in(r_qk[g]), .v_in(r_vk[g]), .cdb_en_in(bus.cdb_en_in), .cdb_tag_in(bus.cdb_tag_in),
      .cdb_value_in(bus.cdb_value_in), .q_out(w_qk[g]), .v_out(w_vk[g]));
  end

  // Dispatch bypass: an operand broadcast in the dispatch cycle is captured immediately
  lsq_wakeup #(.CDB_CH(CDB_CH), .XLEN(XLEN), .TAG_W(TAG_W)) u_wk_dj (
    .q_in(bus.dispatch_qj_in), .v_in(bus.dispatch_vj_in), .cdb_en_in(bus.cdb_en_in),
    .cdb_tag_in(bus.cdb_tag_in), .cdb_value_in(bus.cdb_value_in), .q_out(w_dqj), .v_out(w_dvj));
  lsq_wakeup #(.CDB_CH(CDB_CH), .XLEN(XLEN), .TAG_W(TAG_W)) u_wk_dk (
    .q_in(bus.dispatch_qk_in), .v_in(bus.dispatch_vk_in), .cdb_en_in(bus.cdb_en_in),
    .cdb_tag_in(bus.cdb_tag_in), .cdb_value_in(bus.cdb_value_in), .q_out(w_dqk), .v_out(w_dvk));

  // Head readiness and store-data width shaping, from registered entry state only
  always_comb begin
    w_head_load  = is_load(32'(r_type[r_head]));
    w_head_store = is_store(32'(r_type[r_head]));
    w_issue      = r_valid[r_head] && (r_qj[r_head] == TAG_NONE) &&
                   ((w_head_load && bus.lbuffer_rdy_in) || (w_head_store && (r_qk[r_head] == TAG_NONE)));
    if (32'(r_type[r_head]) == SB) begin
      w_store_data = XLEN'(r_vk[r_head][7:0]);
    end else if (32'(r_type[r_head]) == SH) begin
      w_store_data = XLEN'(r_vk[r_head][15:0]);
    end else begin
      w_store_data = r_vk[r_head];
    end
  end

  // Full check uses registered count, so a same-cycle issue does not make room
  assign w_accept = bus.dispatch_en_in && (r_count != FULL_CNT);

  // Queue state, wakeup, issue pulses and dispatch
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_overflow  <= DISABLE;
      r_rob_en    <= DISABLE;
      r_rob_dest  <= '0;
      r_rob_value <= '0;
      r_addr_en   <= DISABLE;
      r_addr_imm  <= '0;
      r_addr_vj   <= '0;
      r_addr_dest <= '0;
      r_addr_type <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i] <= DISABLE;
        r_type[i]  <= '0;
        r_vj[i]    <= '0;
        r_vk[i]    <= '0;
        r_imm[i]   <= '0;
        r_qj[i]    <= '0;
        r_qk[i]    <= '0;
        r_dest[i]  <= '0;
      end
    end else begin
      r_rob_en    <= DISABLE;
      r_rob_dest  <= '0;
      r_rob_value <= '0;
      r_addr_en   <= DISABLE;
      r_addr_imm  <= '0;
      r_addr_vj   <= '0;
      r_addr_dest <= '0;
      r_addr_type <= '0;
      if (bus.rdy_in) begin
        if (bus.flush_in) begin
          r_head  <= '0;
          r_tail  <= '0;
          r_count <= '0;
          for (int i = 0; i < DEPTH; i++) begin
            r_valid[i] <= DISABLE;
          end
        end else begin
          for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i]) begin
              r_qj[i] <= w_qj[i];
              r_vj[i] <= w_vj[i];
              r_qk[i] <= w_qk[i];
              r_vk[i] <= w_vk[i];
            end
          end
          if (w_issue) begin
            r_addr_en   <= ENABLE;
            r_addr_imm  <= r_imm[r_head];
            r_addr_vj   <= r_vj[r_head];
            r_addr_dest <= r_dest[r_head];
            r_addr_type <= r_type[r_head];
            if (w_head_store) begin
              r_rob_en    <= ENABLE;
              r_rob_dest  <= r_dest[r_head];
              r_rob_value <= w_store_data;
            end
            r_valid[r_head] <= DISABLE;
            r_head          <= r_head + PW'(1);
          end
          if (w_accept) begin
            r_valid[r_tail] <= ENABLE;
            r_type[r_tail]  <= bus.dispatch_type_in;
            r_vj[r_tail]    <= w_dvj;
            r_vk[r_tail]    <= w_dvk;
            r_qj[r_tail]    <= w_dqj;
            r_qk[r_tail]    <= w_dqk;
            r_imm[r_tail]   <= bus.dispatch_imm_in;
            r_dest[r_tail]  <= bus.dispatch_dest_in;
            r_tail          <= r_tail + PW'(1);
          end else if (bus.dispatch_en_in) begin
            r_overflow <= ENABLE;
          end
          if (w_accept && !w_issue) begin
            r_count <= r_count + CW'(1);
          end else if (!w_accept && w_issue) begin
            r_count <= r_count - CW'(1);
          end
        end
      end
    end
  end

  assign bus.instqueue_rdy_out = (r_count <= RDY_MAX);
  assign bus.count_out         = r_count;
  assign bus.overflow_err_out  = r_overflow;
  assign bus.rob_en_out        = r_rob_en;
  assign bus.rob_dest_out      = r_rob_dest;
  assign bus.rob_value_out     = r_rob_value;
  assign bus.addr_en_out       = r_addr_en;
  assign bus.addr_imm_out      = r_addr_imm;
  assign bus.addr_vj_out       = r_addr_vj;
  assign bus.addr_dest_out     = r_addr_dest;
  assign bus.addr_type_out     = r_addr_type;

endmodule
